vga_pixel_feeder: RTL and testbench
===================================

Name: vga_pixel_feeder

Overview:
Avalon-MM write master that drives the framebuffer pixel peripheral from a raster-ordered luminance stream. Accepts one 8-bit pixel per valid/ready handshake. Tracks the (h,v) raster position itself and issues two Avalon writes per pixel: first the coordinate register, then the data register. Sits between a pixel source (decoder/DMA/test-pattern generator) and the peripheral's chipselect/write/address/writedata slave port.

Parameters:
H_ACTIVE, 640, pixels per line; h wraps at H_ACTIVE-1.
V_ACTIVE, 400, lines per frame; 640*400 = 256000 framebuffer bytes.
COORD_ADDR, 8'h01, slave register taking {h[15:0], v[15:0]}.
DATA_ADDR, 8'h00, slave register taking the pixel byte in writedata[7:0].
GAP_CYCLES, 0, idle cycles inserted after each data write (0..15).

Ports:
clk  in  1  system clock (50 MHz domain)
reset  in  1  synchronous, active-high
pix_data  in  8  luminance byte
pix_sof  in  1  qualifies pix_data as first pixel of a frame
pix_valid  in  1  source has a pixel
pix_ready  out  1  block accepts pixel this cycle
chipselect  out  1  Avalon master chipselect
write  out  1  Avalon master write strobe
address  out  8  Avalon word address
writedata  out  32  Avalon write data
waitrequest  in  1  slave stall; tie 0 for the current peripheral
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after the data write of pixel (H_ACTIVE-1, V_ACTIVE-1)
sof_resync  out  1  one-cycle pulse when pix_sof is accepted while h!=0 or v!=0
pixel_count  out  19  pixels written since reset, wraps at 2^19

Behaviour:
- Reset, which dominates all other conditions: state=IDLE, h=v=0, chipselect=write=0, address=0, writedata=0, pix_ready=0, frame_done=0, sof_resync=0, pixel_count=0. Any in-flight pixel is discarded. No partial write persists past the reset edge.
- States and transitions:
  - IDLE: pix_ready=1. On pix_valid&pix_ready, latch pix_data. If pix_sof, set h=v=0 for this pixel, and pulse sof_resync if the old position was nonzero. Go to COORD.
  - COORD: chipselect=write=1, address=COORD_ADDR, writedata={16'(h),16'(v)}. Hold while waitrequest=1. Go to DATA on the edge where waitrequest=0.
  - DATA: chipselect=write=1, address=DATA_ADDR, writedata={24'b0,latched byte}. Hold while waitrequest=1. On completion:
    - Increment pixel_count.
    - Advance the raster position: h+1; at h=H_ACTIVE-1, h=0 and v+1; at v=V_ACTIVE-1, v=0 and pulse frame_done.
    - Go to GAP if GAP_CYCLES>0, else to IDLE.
  - GAP: chipselect=write=0. Count GAP_CYCLES cycles, then go to IDLE.
- Outputs are registered. chipselect, write, address and writedata stay stable for the whole of a stalled transfer.
- Latency: pixel accepted at edge N, COORD write presented in cycle N+1, DATA write in cycle N+2 (no stalls). Throughput is one pixel per 3+GAP_CYCLES cycles; pix_ready is low outside IDLE.
- Write ordering: the coordinate write always precedes the data write. The peripheral needs both writes on consecutive or later cycles, with no other master write in between.
- Widths: h and v are held as 10 bits internally and zero-extended to 16 in writedata. Out-of-range coordinates are impossible by construction.
- Simultaneous events:
  - frame_done and acceptance of the next pixel cannot coincide, because acceptance happens only in IDLE.
  - A pix_sof accepted exactly at h=v=0 produces no sof_resync.

Decomposition:
- Package vga_pkg holds:
  - the register addresses VGA_DATA_ADDR and VGA_COORD_ADDR;
  - the geometry constants H_ACTIVE and V_ACTIVE;
  - typedef feeder_state_t {IDLE, COORD, DATA, GAP};
  - typedef coord_t (10-bit).
- One natural sub-module, raster_counter: h/v counters with advance, clear and wrap, producing the last_pixel flag that drives frame_done.

Test Plan:
- Single pixel 8'hA5 with sof after reset, waitrequest=0:
  - cycle 1: address=1, writedata=32'h0000_0000;
  - cycle 2: address=0, writedata=32'h0000_00A5;
  - pixel_count becomes 1, h=1.
- Stream 641 pixels: the 641st coordinate write carries writedata=32'h0000_0001 (h=0, v=1), and the 640th carries 32'h027F_0000.
- Full 256000-pixel frame: exactly one frame_done pulse, one cycle after the data write carrying coord 32'h027F_018F; next coordinate 32'h0000_0000.
- waitrequest held high 5 cycles during COORD, then 3 during DATA: outputs remain constant while stalled, writes complete once each, and pix_ready stays low throughout.
- pix_sof at position (h=10, v=3): sof_resync pulses once, and the coordinate write is 32'h0000_0000.
- Assert reset during DATA with GAP_CYCLES=2: write=0 and state IDLE on the next edge, pixel_count unchanged. The first post-reset pixel goes to (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel feeder: register map, raster geometry, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: slave register addresses, active raster size, coordinate type,
// feeder FSM state encoding and the coordinate-register packing helper.
package vga_pkg;

    localparam int         H_ACTIVE       = 640;
    localparam int         V_ACTIVE       = 400;
    localparam logic [7:0] VGA_DATA_ADDR  = 8'h00;
    localparam logic [7:0] VGA_COORD_ADDR = 8'h01;
    localparam int         COORD_W        = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COORD = 2'd1,
        DATA  = 2'd2,
        GAP   = 2'd3
    } feeder_state_t;

    // Coordinate register layout: {h[15:0], v[15:0]}, zero-extended from 10 bits.
    function automatic logic [31:0] pack_coord(input coord_t h, input coord_t v);
        return {16'(h), 16'(v)};
    endfunction

endpackage

// File: rtl/vga_pixel_feeder_raster_counter.sv
// Raster position tracker: h/v counters with clear, advance and wrap at the active size.
// Latency: position updates on the edge where clear or advance is sampled; flags are combinational.
// Backpressure: none; the owner only pulses advance once per completed pixel.
//
// Ports: clk, reset (sync, active-high), clear (jump to origin), advance (step one pixel),
//        h/v (current position), last_pixel (at H_SIZE-1, V_SIZE-1), at_origin (at 0,0).
module raster_counter
    import vga_pkg::*;
#(
    parameter int H_SIZE = H_ACTIVE,
    parameter int V_SIZE = V_ACTIVE
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clear,
    input  logic   advance,
    output coord_t h,
    output coord_t v,
    output logic   last_pixel,
    output logic   at_origin
);

    logic h_last;
    logic v_last;

    assign h_last     = (h == coord_t'(H_SIZE - 1));
    assign v_last     = (v == coord_t'(V_SIZE - 1));
    assign last_pixel = h_last && v_last;
    assign at_origin  = (h == '0) && (v == '0);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            h <= '0;
            v <= '0;
        end else if (advance) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Avalon-MM write master turning a raster-ordered pixel stream into coord+data register writes.
// Latency: pixel accepted at edge N -> coord write in cycle N+1, data write in cycle N+2 (no stalls).
// Backpressure: pix_ready only in IDLE; waitrequest holds the current write stable until it drops.
//
// Ports: clk, reset (sync, active-high); pixel stream pix_data/pix_sof/pix_valid/pix_ready;
//        Avalon master chipselect/write/address/writedata/waitrequest;
//        status busy, frame_done (pulse), sof_resync (pulse), pixel_count (19-bit, wraps).
module vga_pixel_feeder #(
    parameter int         H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int         V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter logic [7:0] COORD_ADDR = vga_pkg::VGA_COORD_ADDR,
    parameter logic [7:0] DATA_ADDR  = vga_pkg::VGA_DATA_ADDR,
    parameter int         GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pix_data,
    input  logic        pix_sof,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        chipselect,
    output logic        write,
    output logic [7:0]  address,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    output logic        busy,
    output logic        frame_done,
    output logic        sof_resync,
    output logic [18:0] pixel_count
);

    import vga_pkg::*;

    // Gap counter is loaded with the last index so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    feeder_state_t state;
    feeder_state_t state_next;

    coord_t      h;
    coord_t      v;
    logic        last_pixel;
    logic        at_origin;
    logic        accept;
    logic        data_done;
    logic [7:0]  pix_byte;
    logic [3:0]  gap_cnt;
    logic        cs_next;
    logic [7:0]  addr_next;
    logic [31:0] wd_next;

    assign accept    = (state == IDLE) && pix_valid && pix_ready;
    assign data_done = (state == DATA) && !waitrequest;

    raster_counter #(
        .H_SIZE (H_ACTIVE),
        .V_SIZE (V_ACTIVE)
    ) u_raster (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept && pix_sof),
        .advance    (data_done),
        .h          (h),
        .v          (v),
        .last_pixel (last_pixel),
        .at_origin  (at_origin)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the next value of the registered bus outputs. Bus fields
    // default to holding, which keeps a stalled transfer stable.
    always_comb begin
        state_next = state;
        cs_next    = chipselect;
        addr_next  = address;
        wd_next    = writedata;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = COORD;
                    cs_next    = 1'b1;
                    addr_next  = COORD_ADDR;
                    // A start-of-frame pixel lands at the origin whatever the counter holds.
                    wd_next    = pix_sof ? 32'h0 : pack_coord(h, v);
                end
            end
            COORD: begin
                if (!waitrequest) begin
                    state_next = DATA;
                    addr_next  = DATA_ADDR;
                    wd_next    = {24'h0, pix_byte};
                end
            end
            DATA: begin
                if (!waitrequest) begin
                    state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
                    cs_next    = 1'b0;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cs_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chipselect  <= 1'b0;
            write       <= 1'b0;
            address     <= 8'h0;
            writedata   <= 32'h0;
            pix_ready   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            sof_resync  <= 1'b0;
            pixel_count <= 19'h0;
            pix_byte    <= 8'h0;
            gap_cnt     <= 4'h0;
        end else begin
            chipselect <= cs_next;
            write      <= cs_next;
            address    <= addr_next;
            writedata  <= wd_next;
            pix_ready  <= (state_next == IDLE);
            busy       <= (state_next != IDLE);
            frame_done <= data_done && last_pixel;
            sof_resync <= accept && pix_sof && !at_origin;
            if (accept) begin
                pix_byte <= pix_data;
            end
            if (data_done) begin
                pixel_count <= pixel_count + 19'd1;
            end
            if (data_done) begin
                gap_cnt <= GAP_LAST;
            end else if ((state == GAP) && (gap_cnt != 4'd0)) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Testbench for vga_pixel_feeder: full-size instance (a) plus a small-raster instance (b)
// with an 8x4 frame and two gap cycles so whole frames fit in a short run.
module tb_vga_pixel_feeder;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: 640x400, no gap
    logic        rst_a, ps_a, pv_a, rdy_a, cs_a, wr_a, wait_a, busy_a, fd_a, rs_a;
    logic [7:0]  pd_a, ad_a;
    logic [31:0] wd_a;
    logic [18:0] pc_a;
    // Instance b: 8x4, two gap cycles
    logic        rst_b, ps_b, pv_b, rdy_b, cs_b, wr_b, wait_b, busy_b, fd_b, rs_b;
    logic [7:0]  pd_b, ad_b;
    logic [31:0] wd_b;
    logic [18:0] pc_b;

    vga_pixel_feeder dut_a (
        .clk(clk), .reset(rst_a), .pix_data(pd_a), .pix_sof(ps_a), .pix_valid(pv_a),
        .pix_ready(rdy_a), .chipselect(cs_a), .write(wr_a), .address(ad_a),
        .writedata(wd_a), .waitrequest(wait_a), .busy(busy_a), .frame_done(fd_a),
        .sof_resync(rs_a), .pixel_count(pc_a)
    );

    vga_pixel_feeder #(.H_ACTIVE(8), .V_ACTIVE(4), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .reset(rst_b), .pix_data(pd_b), .pix_sof(ps_b), .pix_valid(pv_b),
        .pix_ready(rdy_b), .chipselect(cs_b), .write(wr_b), .address(ad_b),
        .writedata(wd_b), .waitrequest(wait_b), .busy(busy_b), .frame_done(fd_b),
        .sof_resync(rs_b), .pixel_count(pc_b)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: {address, writedata} expected per completed bus write.
    logic [39:0] exp_a[$];
    logic [39:0] exp_b[$];
    logic [39:0] e_a, e_b;
    logic [31:0] last_coord_a, last_coord_b;
    int          fd_cnt_a = 0, fd_cnt_b = 0, rs_cnt_a = 0;

    // Reference raster position per instance
    int mh[2];
    int mv[2];

    always @(negedge clk) begin
        if (cs_a && wr_a && !wait_a) begin
            checks++;
            if (exp_a.size() == 0) begin
                failures++;
                $display("FAIL bus_a_unexpected got addr=%h data=%h, none expected", ad_a, wd_a);
            end else begin
                e_a = exp_a.pop_front();
                if ({ad_a, wd_a} !== e_a) begin
                    failures++;
                    $display("FAIL bus_a_write got=%h want=%h", {ad_a, wd_a}, e_a);
                end
            end
            if (ad_a == 8'h01) last_coord_a = wd_a;
        end
        if (cs_b && wr_b && !wait_b) begin
            checks++;
            if (exp_b.size() == 0) begin
                failures++;
                $display("FAIL bus_b_unexpected got addr=%h data=%h, none expected", ad_b, wd_b);
            end else begin
                e_b = exp_b.pop_front();
                if ({ad_b, wd_b} !== e_b) begin
                    failures++;
                    $display("FAIL bus_b_write got=%h want=%h", {ad_b, wd_b}, e_b);
                end
            end
            if (ad_b == 8'h01) last_coord_b = wd_b;
        end
        if (fd_a === 1'b1) fd_cnt_a++;
        if (fd_b === 1'b1) fd_cnt_b++;
        if (rs_a === 1'b1) rs_cnt_a++;
    end

    // Push expected writes, offer one pixel and return #1 after the accepting edge.
    task automatic send(input bit s, input logic [7:0] d, input logic sof, output logic [31:0] coord);
        int t;
        int hs, vs;
        hs = s ? 8 : 640;
        vs = s ? 4 : 400;
        if (sof) begin
            mh[s] = 0;
            mv[s] = 0;
        end
        coord = {16'(mh[s]), 16'(mv[s])};
        if (s) begin
            exp_b.push_back({8'h01, coord});
            exp_b.push_back({8'h00, 24'h0, d});
        end else begin
            exp_a.push_back({8'h01, coord});
            exp_a.push_back({8'h00, 24'h0, d});
        end
        if (mh[s] == hs - 1) begin
            mh[s] = 0;
            mv[s] = (mv[s] == vs - 1) ? 0 : mv[s] + 1;
        end else begin
            mh[s] = mh[s] + 1;
        end
        @(negedge clk);
        if (s) begin pd_b = d; ps_b = sof; pv_b = 1'b1; end
        else   begin pd_a = d; ps_a = sof; pv_a = 1'b1; end
        t = 0;
        while (!(s ? rdy_b : rdy_a) && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            failures++;
            $display("FAIL accept_timeout inst=%0d pix_ready stayed low for %0d cycles, need high", s, t);
        end
        @(posedge clk);
        #1;
        if (s) begin pv_b = 1'b0; ps_b = 1'b0; end
        else   begin pv_a = 1'b0; ps_a = 1'b0; end
    endtask

    // Wait (bounded) for all expected writes to appear, then let counters settle.
    task automatic drain(input bit s, output bit ok);
        int t;
        t = 0;
        while ((s ? exp_b.size() : exp_a.size()) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = ((s ? exp_b.size() : exp_a.size()) == 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({cs_a, wr_a, ad_a, wd_a, rdy_a, busy_a, fd_a, rs_a, pc_a} !== '0) begin
            failures++;
            $display("FAIL reset_a outputs got cs=%b wr=%b addr=%h wd=%h rdy=%b busy=%b fd=%b rs=%b pc=%0d, need all 0",
                     cs_a, wr_a, ad_a, wd_a, rdy_a, busy_a, fd_a, rs_a, pc_a);
        end
        checks++;
        if ({cs_b, wr_b, ad_b, wd_b, rdy_b, busy_b, fd_b, rs_b, pc_b} !== '0) begin
            failures++;
            $display("FAIL reset_b outputs got cs=%b wr=%b addr=%h wd=%h rdy=%b busy=%b fd=%b rs=%b pc=%0d, need all 0",
                     cs_b, wr_b, ad_b, wd_b, rdy_b, busy_b, fd_b, rs_b, pc_b);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rdy_a !== 1'b1 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got rdy=%b busy=%b, need rdy=1 busy=0", rdy_a, busy_a);
        end
    endtask

    task automatic test_single_pixel;
        logic [31:0] c;
        int          rs0;
        bit          ok;
        rs0 = rs_cnt_a;
        send(0, 8'hA5, 1'b1, c);
        @(negedge clk);
        checks++;
        if ({cs_a, wr_a, ad_a, wd_a} !== {1'b1, 1'b1, 8'h01, 32'h0000_0000}) begin
            failures++;
            $display("FAIL single_coord_cycle got cs=%b wr=%b addr=%h wd=%h, need 1 1 01 00000000", cs_a, wr_a, ad_a, wd_a);
        end
        checks++;
        if (rdy_a !== 1'b0) begin
            failures++;
            $display("FAIL single_ready_low got rdy=%b, need 0", rdy_a);
        end
        @(negedge clk);
        checks++;
        if ({cs_a, wr_a, ad_a, wd_a} !== {1'b1, 1'b1, 8'h00, 32'h0000_00A5}) begin
            failures++;
            $display("FAIL single_data_cycle got cs=%b wr=%b addr=%h wd=%h, need 1 1 00 000000a5", cs_a, wr_a, ad_a, wd_a);
        end
        @(negedge clk);
        checks++;
        if (pc_a !== 19'd1 || cs_a !== 1'b0 || rdy_a !== 1'b1) begin
            failures++;
            $display("FAIL single_done got pc=%0d cs=%b rdy=%b, need pc=1 cs=0 rdy=1", pc_a, cs_a, rdy_a);
        end
        checks++;
        if (rs_cnt_a != rs0) begin
            failures++;
            $display("FAIL sof_at_origin got %0d resync pulses, need 0", rs_cnt_a - rs0);
        end
        send(0, 8'h11, 1'b0, c);
        drain(0, ok);
        checks++;
        if (!ok || last_coord_a !== 32'h0001_0000) begin
            failures++;
            $display("FAIL second_pixel_h1 got coord=%h drained=%b, need 00010000 drained=1", last_coord_a, ok);
        end
    endtask

    task automatic test_line_wrap;
        logic [31:0] c;
        logic [18:0] pc0;
        bit          ok;
        pc0 = pc_a;
        for (int i = 0; i < 640; i++) send(0, 8'(i) ^ 8'h5A, (i == 0), c);
        drain(0, ok);
        checks++;
        if (!ok || last_coord_a !== 32'h027F_0000) begin
            failures++;
            $display("FAIL coord_640th got=%h drained=%b, need 027f0000 drained=1", last_coord_a, ok);
        end
        send(0, 8'hC3, 1'b0, c);
        drain(0, ok);
        checks++;
        if (!ok || last_coord_a !== 32'h0000_0001) begin
            failures++;
            $display("FAIL coord_641st got=%h drained=%b, need 00000001 drained=1", last_coord_a, ok);
        end
        checks++;
        if (pc_a !== 19'(pc0 + 19'd641)) begin
            failures++;
            $display("FAIL pixel_count_line got=%0d, need %0d", pc_a, 19'(pc0 + 19'd641));
        end
    endtask

    task automatic test_sof_resync;
        logic [31:0] c;
        int          n;
        int          rs0;
        bit          ok;
        n = 0;
        while (!(mh[0] == 10 && mv[0] == 3) && n < 3000) begin
            send(0, 8'(n) + 8'h21, 1'b0, c);
            n++;
        end
        drain(0, ok);
        rs0 = rs_cnt_a;
        send(0, 8'hE7, 1'b1, c);
        drain(0, ok);
        checks++;
        if (rs_cnt_a - rs0 != 1) begin
            failures++;
            $display("FAIL sof_resync_pulses got=%0d, need 1", rs_cnt_a - rs0);
        end
        checks++;
        if (!ok || last_coord_a !== 32'h0000_0000) begin
            failures++;
            $display("FAIL sof_resync_coord got=%h drained=%b, need 00000000 drained=1", last_coord_a, ok);
        end
    endtask

    task automatic test_stall;
        logic [31:0] c;
        logic [18:0] pc0;
        bit          ok;
        pc0 = pc_a;
        wait_a = 1'b1;
        send(0, 8'h3C, 1'b0, c);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({cs_a, wr_a, ad_a, wd_a, rdy_a} !== {1'b1, 1'b1, 8'h01, c, 1'b0}) begin
                failures++;
                $display("FAIL stall_coord[%0d] got cs=%b wr=%b addr=%h wd=%h rdy=%b, need 1 1 01 %h 0",
                         i, cs_a, wr_a, ad_a, wd_a, rdy_a, c);
            end
            @(posedge clk);
            #1;
        end
        wait_a = 1'b0;
        @(posedge clk);
        #1;
        wait_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({cs_a, wr_a, ad_a, wd_a, rdy_a} !== {1'b1, 1'b1, 8'h00, 32'h0000_003C, 1'b0}) begin
                failures++;
                $display("FAIL stall_data[%0d] got cs=%b wr=%b addr=%h wd=%h rdy=%b, need 1 1 00 0000003c 0",
                         i, cs_a, wr_a, ad_a, wd_a, rdy_a);
            end
            @(posedge clk);
            #1;
        end
        wait_a = 1'b0;
        drain(0, ok);
        checks++;
        if (!ok || pc_a !== 19'(pc0 + 19'd1)) begin
            failures++;
            $display("FAIL stall_complete got pc=%0d drained=%b, need pc=%0d drained=1", pc_a, ok, 19'(pc0 + 19'd1));
        end
    endtask

    task automatic test_reset_in_data;
        logic [31:0] c;
        send(1, 8'h77, 1'b1, c);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ad_b !== 8'h00 || wr_b !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_in_data got addr=%h wr=%b, need 00 1", ad_b, wr_b);
        end
        rst_b = 1'b1;
        @(negedge clk);
        checks++;
        if ({cs_b, wr_b, busy_b, rdy_b, fd_b, pc_b} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got cs=%b wr=%b busy=%b rdy=%b fd=%b pc=%0d, need all 0",
                     cs_b, wr_b, busy_b, rdy_b, fd_b, pc_b);
        end
        checks++;
        if (exp_b.size() != 0) begin
            failures++;
            $display("FAIL rst_mid_pending got %0d writes outstanding, need 0", exp_b.size());
        end
        rst_b = 1'b0;
        mh[1] = 0;
        mv[1] = 0;
    endtask

    task automatic test_frame_done;
        logic [31:0] c;
        int          fd0;
        bit          ok;
        fd0 = fd_cnt_b;
        send(1, 8'h80, 1'b0, c);
        drain(1, ok);
        checks++;
        if (!ok || last_coord_b !== 32'h0000_0000) begin
            failures++;
            $display("FAIL post_reset_origin got=%h drained=%b, need 00000000 drained=1", last_coord_b, ok);
        end
        for (int i = 1; i < 31; i++) send(1, 8'(i) + 8'h80, 1'b0, c);
        send(1, 8'hFF, 1'b0, c);
        @(negedge clk);
        checks++;
        if (ad_b !== 8'h01 || wd_b !== 32'h0007_0003 || fd_b !== 1'b0) begin
            failures++;
            $display("FAIL frame_last_coord got addr=%h wd=%h fd=%b, need 01 00070003 0", ad_b, wd_b, fd_b);
        end
        @(negedge clk);
        checks++;
        if (ad_b !== 8'h00 || fd_b !== 1'b0) begin
            failures++;
            $display("FAIL frame_last_data got addr=%h fd=%b, need 00 0", ad_b, fd_b);
        end
        @(negedge clk);
        checks++;
        if (fd_b !== 1'b1 || busy_b !== 1'b1 || rdy_b !== 1'b0 || cs_b !== 1'b0) begin
            failures++;
            $display("FAIL frame_done_pulse got fd=%b busy=%b rdy=%b cs=%b, need 1 1 0 0", fd_b, busy_b, rdy_b, cs_b);
        end
        @(negedge clk);
        checks++;
        if (fd_b !== 1'b0 || rdy_b !== 1'b0 || busy_b !== 1'b1) begin
            failures++;
            $display("FAIL gap_second got fd=%b rdy=%b busy=%b, need 0 0 1", fd_b, rdy_b, busy_b);
        end
        @(negedge clk);
        checks++;
        if (rdy_b !== 1'b1 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL gap_end got rdy=%b busy=%b, need 1 0", rdy_b, busy_b);
        end
        checks++;
        if (fd_cnt_b - fd0 != 1) begin
            failures++;
            $display("FAIL frame_done_count got=%0d, need 1", fd_cnt_b - fd0);
        end
        send(1, 8'h01, 1'b0, c);
        drain(1, ok);
        checks++;
        if (!ok || last_coord_b !== 32'h0000_0000 || pc_b !== 19'd33) begin
            failures++;
            $display("FAIL next_frame got coord=%h pc=%0d drained=%b, need 00000000 33 1", last_coord_b, pc_b, ok);
        end
        checks++;
        if (fd_cnt_a != 0) begin
            failures++;
            $display("FAIL frame_done_a_spurious got=%0d pulses, need 0", fd_cnt_a);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        pd_a = 8'h0; ps_a = 1'b0; pv_a = 1'b0; wait_a = 1'b0;
        pd_b = 8'h0; ps_b = 1'b0; pv_b = 1'b0; wait_b = 1'b0;
        mh[0] = 0; mv[0] = 0; mh[1] = 0; mv[1] = 0;
        last_coord_a = 32'hDEAD_BEEF;
        last_coord_b = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        test_reset();
        test_single_pixel();
        test_line_wrap();
        test_sof_resync();
        test_stall();
        test_reset_in_data();
        test_frame_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
